// File: rtl/sram_like_mem_responder_if.sv
// sram-like bus bundle between a CPU port (master) and a memory responder (slave).
//   req/wr/size/addr/wdata : request from master
//   addr_ok                : request accepted this cycle (combinational in slave)
//   data_ok/rdata          : one-cycle in-order completion with read data
interface sram_like_mem_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, rdata, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, rdata, data_ok
  );
endinterface

// File: rtl/sram_like_mem_responder.sv
// Word-organised memory behind an sram-like bus with fixed response latency and a bounded
// in-order queue of accepted-but-unanswered requests.
//   clk  : clock, all state on rising edge
//   rstn : asynchronous active-low reset (queue state only; array contents persist)
//   bus  : sram-like slave modport (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out)
// Parameters: ADDR_WIDTH word-address bits, LATENCY 1..15, QUEUE_DEPTH 1..4.
module sram_like_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  sram_like_mem_responder_if.slave  bus
);

  localparam int unsigned PtrW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [3:0]  TimerInit = 4'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0]      timer_q [QUEUE_DEPTH];
  logic [3:0]      timer_d [QUEUE_DEPTH];
  logic [31:0]     value_q [QUEUE_DEPTH];
  logic [31:0]     value_d [QUEUE_DEPTH];
  logic            data_ok_q, data_ok_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            be;
  logic                  misaligned;
  logic                  addr_ok;
  logic                  hs;
  logic                  head_ready;
  logic                  bypass;
  logic                  push;
  logic [31:0]           push_value;
  logic                  unused_addr_bits;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign word_idx         = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (bus.size)
      2'd0: be = 4'b0001 << bus.addr[1:0];
      2'd1: begin
        be         = bus.addr[1] ? 4'b1100 : 4'b0011;
        misaligned = bus.addr[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = |bus.addr[1:0];
      end
    endcase
  end

  // No same-cycle pop bypass on acceptance: a full queue blocks even while popping.
  assign addr_ok = rstn & bus.req & (count_q < CntW'(QUEUE_DEPTH));
  assign hs      = bus.req & addr_ok;

  // One handshake per cycle, so the read value here never races a write to the same word.
  assign push_value = bus.wr ? 32'h0 : mem[word_idx];

  // Timers load LATENCY-1 and fall by one per edge, so the head is due on the edge where
  // its timer steps 1->0 (or is already 0 after waiting behind an older entry).
  assign head_ready = (count_q != '0) && (timer_q[head_q] <= 4'd1);

  // With LATENCY=1 and nothing queued the response is due on the handshake edge itself;
  // the entry never occupies a slot.
  assign bypass = (LATENCY == 1) && hs && (count_q == '0);
  assign push   = hs & ~bypass;

  always_comb begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      timer_d[i] = (timer_q[i] != 4'd0) ? timer_q[i] - 4'd1 : 4'd0;
      value_d[i] = value_q[i];
    end
    if (push) begin
      timer_d[tail_q] = TimerInit;
      value_d[tail_q] = push_value;
    end

    head_d = head_ready ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;

    count_d = count_q;
    case ({push, head_ready})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    data_ok_d = head_ready | bypass;
    rdata_d   = rdata_q;
    if (head_ready) begin
      rdata_d = value_q[head_q];
    end else if (bypass) begin
      rdata_d = push_value;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        timer_q[i] <= 4'd0;
        value_q[i] <= 32'h0;
      end
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        timer_q[i] <= timer_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

  // Misaligned writes are acknowledged but never reach the array.
  always_ff @(posedge clk) begin
    if (hs && bus.wr && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

endmodule
